// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_ADDR_W    = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTES_PER_WORD * 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // A header is usable only if it names between 1 and depth words.
    function automatic logic header_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (32'(n) <= 32'(depth));
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian words from accepted stream bytes; word_valid pulses
// for one cycle after the last byte of each word, while word holds the result.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [7:0]        byte_data,
    input  logic              byte_en,
    output logic [LANE_W-1:0] lane,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic last_lane;

    assign last_lane = (lane == LANE_W'(BYTES_PER_WORD - 1));

    // Bytes enter at the top and move down, so the first byte of a word lands in [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clear) begin
            lane       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= byte_en && last_lane;
            if (byte_en) begin
                word <= {byte_data, word[WORD_W-1:8]};
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a word-count-framed byte stream into instruction memory and holds the CPU
// until the image is complete. Define IMEM_LOADER_CHKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  word_cnt, word_cnt_next;
    logic [CNT_W-1:0]  n_words, n_words_next;
    logic [ADDR_W-1:0] waddr_next;
    logic              in_ready_next, cpu_hold_next, done_next, err_next;
    logic              accept, pack_clear, pack_en, word_last;
    logic [LANE_W-1:0] lane;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]        chk, chk_next;
`endif

    assign accept    = in_valid && in_ready;
    assign word_last = (lane == LANE_W'(BYTES_PER_WORD - 1));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_data  (in_data),
        .byte_en    (pack_en),
        .lane       (lane),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            n_words    <= '0;
            imem_waddr <= '0;
            in_ready   <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk        <= 8'd0;
`endif
        end else begin
            state      <= state_next;
            word_cnt   <= word_cnt_next;
            n_words    <= n_words_next;
            imem_waddr <= waddr_next;
            in_ready   <= in_ready_next;
            cpu_hold   <= cpu_hold_next;
            done       <= done_next;
            err        <= err_next;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk        <= chk_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        n_words_next  = n_words;
        waddr_next    = imem_waddr;
        cpu_hold_next = cpu_hold;
        err_next      = err;
        done_next     = 1'b0;
        pack_clear    = 1'b0;
        pack_en       = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_next      = chk;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (header_ok(in_data, DEPTH)) begin
                        err_next      = 1'b0;
                        cpu_hold_next = 1'b1;
                        word_cnt_next = '0;
                        n_words_next  = CNT_W'(in_data);
                        pack_clear    = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk_next      = 8'd0;
`endif
                        state_next    = DATA;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    pack_en = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_next = chk ^ in_data;
`endif
                    // Address is latched with the word so it lines up with the write strobe.
                    if (word_last) begin
                        waddr_next    = ADDR_W'(word_cnt);
                        word_cnt_next = word_cnt + 1'b1;
                        if (word_cnt == n_words - 1'b1) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            state_next = CHK;
`else
                            state_next = DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_data == chk) begin
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                done_next     = 1'b1;
                cpu_hold_next = 1'b0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Ready is registered from the next state so it always matches the state it gates.
        in_ready_next = (state_next != DONE);
    end

    a_waddr_in_range: assert property (@(posedge clk) disable iff (rst)
        imem_we |-> (imem_waddr < ADDR_W'(DEPTH)));

    a_done_releases_cpu: assert property (@(posedge clk) disable iff (rst)
        done |-> !cpu_hold);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level byte-stream model.
module tb_imem_loader;

    localparam int DEPTH = 64;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    bit          exp_ready, exp_we, exp_hold, exp_done, exp_err;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    // Frame-level model state
    bit          in_frame, pending_finish;
    int          n_words, nbytes;
    logic [31:0] acc_word;
    logic [7:0]  xsum;
    logic [31:0] mmem [DEPTH];
    logic [31:0] dmem [DEPTH];

    // Observations of the DUT
    logic [7:0]  wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc  [$];
    int          done_cyc  [$];
    int          cyc = 0;

    logic [7:0]  body_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_ready = 1'b0; exp_we = 1'b0; exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
        exp_addr = 8'd0; exp_data = 32'd0;
        in_frame = 1'b0; pending_finish = 1'b0; nbytes = 0; n_words = 0;
        acc_word = 32'd0; xsum = 8'd0;
    endtask

    // Advances the model by one clock edge given the inputs present at that edge.
    task automatic model_step(input bit v, input logic [7:0] d);
        bit acc;
        acc = v && exp_ready;
        exp_we = 1'b0;
        exp_done = 1'b0;
        exp_ready = 1'b1;
        if (pending_finish) begin
            exp_done = 1'b1;
            exp_hold = 1'b0;
            pending_finish = 1'b0;
        end
        if (acc) begin
            if (!in_frame) begin
                if (d == 8'd0 || int'(d) > DEPTH) begin
                    exp_err = 1'b1;
                end else begin
                    exp_err = 1'b0; exp_hold = 1'b1; in_frame = 1'b1;
                    n_words = int'(d); nbytes = 0; acc_word = 32'd0; xsum = 8'd0;
                end
            end else if (nbytes < 4 * n_words) begin
                acc_word = acc_word | (32'(d) << (8 * (nbytes % 4)));
                xsum = xsum ^ d;
                nbytes++;
                if (nbytes % 4 == 0) begin
                    exp_we = 1'b1;
                    exp_addr = 8'(nbytes / 4 - 1);
                    exp_data = acc_word;
                    mmem[nbytes / 4 - 1] = acc_word;
                    acc_word = 32'd0;
                    if (nbytes == 4 * n_words && !CHK_EN) begin
                        in_frame = 1'b0; pending_finish = 1'b1; exp_ready = 1'b0;
                    end
                end
            end else begin
                in_frame = 1'b0;
                if (d == xsum) begin
                    pending_finish = 1'b1; exp_ready = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    // Single compare process: outputs are checked mid-cycle against the model.
    always @(negedge clk) begin
        check("in_ready", in_ready, exp_ready);
        check("imem_we", imem_we, exp_we);
        check("cpu_hold", cpu_hold, exp_hold);
        check("done", done, exp_done);
        check("err", err, exp_err);
        if (exp_we) begin
            check("imem_waddr", imem_waddr, exp_addr);
            check("imem_wdata", imem_wdata, exp_data);
        end
        if (imem_we) begin
            wlog_addr.push_back(imem_waddr);
            wlog_data.push_back(imem_wdata);
            wlog_cyc.push_back(cyc);
            if (int'(imem_waddr) < DEPTH) dmem[imem_waddr] = imem_wdata;
        end
        if (done) done_cyc.push_back(cyc);
        cyc++;
    end

    task automatic tick(output bit acc);
        @(posedge clk);
        acc = in_valid && exp_ready && !rst;
        #1;
        if (!rst) model_step(in_valid, in_data);
    endtask

    task automatic idle_ticks(input int n);
        bit a;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            tick(a);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int idle_pct);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a) begin
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL send_byte_timeout actual=not_accepted required=accepted (t=%0t)", $time);
                in_valid = 1'b0;
                return;
            end
            if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data = d;
            end
            tick(a);
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int idle_pct, input bit toggle,
                              input int gap_at, input logic [7:0] chk_flip);
        logic [7:0] x;
        x = 8'h00;
        send_byte(hdr, idle_pct);
        if (toggle) idle_ticks(1);
        foreach (body_q[i]) begin
            send_byte(body_q[i], idle_pct);
            x = x ^ body_q[i];
            if (toggle) idle_ticks(1);
            if (i == gap_at) idle_ticks(5);
        end
        if (CHK_EN) send_byte(x ^ chk_flip, idle_pct);
        idle_ticks(3);
    endtask

    task automatic check_image(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (dmem[i] !== mmem[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_waddr", imem_waddr, 8'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        idle_ticks(2);
        rst = 1'b0;
    endtask

    task automatic load_test1_body();
        body_q = {8'h13, 8'h01, 8'h00, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, dbase, bad, nw;
        logic [7:0] hdr;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("init_cpu_hold", cpu_hold, 1'b1);
        check("init_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-word program, continuous valid
        base = wlog_addr.size();
        dbase = done_cyc.size();
        load_test1_body();
        send_frame(8'h02, 0, 1'b0, -1, 8'h00);
        check("t1_nwrites", wlog_addr.size() - base, 2);
        check("t1_addr0", wlog_addr[base], 8'd0);
        check("t1_data0", wlog_data[base], 32'h02000113);
        check("t1_addr1", wlog_addr[base + 1], 8'd1);
        check("t1_data1", wlog_data[base + 1], 32'h00100093);
        check("t1_ndone", done_cyc.size() - dbase, 1);
`ifndef IMEM_LOADER_CHKSUM_EN
        check("t1_done_lat", done_cyc[$], wlog_cyc[base + 1] + 1);
`endif
        check("t1_hold_released", cpu_hold, 1'b0);

        // Same frame, valid toggling with a 5-cycle mid-word gap
        base = wlog_addr.size();
        load_test1_body();
        send_frame(8'h02, 0, 1'b1, 5, 8'h00);
        check("t2_nwrites", wlog_addr.size() - base, 2);
        check("t2_data0", wlog_data[base], 32'h02000113);
        check("t2_data1", wlog_data[base + 1], 32'h00100093);

        // Illegal headers, then a one-word frame
        @(posedge clk);
        #1;
        do_reset();
        base = wlog_addr.size();
        dbase = done_cyc.size();
        send_byte(8'h00, 0);
        check("hdr0_err", err, 1'b1);
        check("hdr0_hold", cpu_hold, 1'b1);
        send_byte(8'h41, 0);
        check("hdr65_err", err, 1'b1);
        idle_ticks(2);
        check("bad_hdr_nwrites", wlog_addr.size() - base, 0);
        send_byte(8'h01, 0);
        check("hdr_ok_err_clear", err, 1'b0);
        send_byte(8'h13, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        if (CHK_EN) send_byte(8'h10, 0);
        idle_ticks(3);
        check("t3_nwrites", wlog_addr.size() - base, 1);
        check("t3_ndone", done_cyc.size() - dbase, 1);

        // Full-depth frame
        base = wlog_addr.size();
        body_q.delete();
        for (int i = 0; i < 4 * DEPTH; i++) body_q.push_back(8'($urandom));
        send_frame(8'(DEPTH), 25, 1'b0, -1, 8'h00);
        check("full_nwrites", wlog_addr.size() - base, DEPTH);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(wlog_addr[base + i]) != i) bad++;
        check("full_addr_order", bad, 0);
        check("full_last_addr", wlog_addr[$], 8'd63);
        check_image("full_image", DEPTH);

        // Reset after 6 data bytes of a 3-word frame
        send_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 0);
        do_reset();
        base = wlog_addr.size();
        body_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(8'h01, 0, 1'b0, -1, 8'h00);
        check("post_rst_nwrites", wlog_addr.size() - base, 1);
        check("post_rst_addr", wlog_addr[$], 8'd0);
        check("post_rst_data", wlog_data[$], 32'hD4C3B2A1);

`ifdef IMEM_LOADER_CHKSUM_EN
        dbase = done_cyc.size();
        body_q = {8'h13, 8'h01, 8'h00, 8'h02};
        send_frame(8'h01, 0, 1'b0, -1, 8'h00);
        check("chk_good_done", done_cyc.size() - dbase, 1);
        check("chk_good_hold", cpu_hold, 1'b0);
        dbase = done_cyc.size();
        send_frame(8'h01, 0, 1'b0, -1, 8'h01);
        check("chk_bad_done", done_cyc.size() - dbase, 0);
        check("chk_bad_err", err, 1'b1);
        check("chk_bad_hold", cpu_hold, 1'b1);
`endif

        // Random frames and bad headers
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                hdr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255));
                send_byte(hdr, int'($urandom_range(0, 50)));
                idle_ticks(int'($urandom_range(0, 3)));
            end else begin
                nw = int'($urandom_range(1, 8));
                body_q.delete();
                for (int i = 0; i < 4 * nw; i++) body_q.push_back(8'($urandom));
                send_frame(8'(nw), int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 4 * nw)),
                           ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
                check_image("rand_image", nw);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the CPU instruction ROM: loads a program image from a byte stream into the instruction memory's write port instead of fixed reset-time contents.
- Assembles little-endian 32-bit instruction words from a valid/ready byte stream framed by a word-count header.
- Holds the 5-stage pipeline in reset (cpu_hold) until a complete, valid image has been written.

Parameters:
- ADDR_W, 8, instruction memory word-address width (matches fetch addr[7:0]).
- DEPTH, 64, number of instruction words in memory; maximum legal frame length.
- DATA_W, 32, instruction word width; fixed at 32, byte assembly assumes 4 bytes per word.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid & in_ready at posedge clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_waddr  out  ADDR_W  word address of write.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  pipeline held in reset while high.
- done  out  1  one-cycle pulse: image loaded successfully.
- err  out  1  sticky error flag; cleared by the next accepted header byte.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE, byte counter=0, word counter=0.
- All outputs are registered.
- Frame format: byte 0 = N (word count), then 4*N data bytes, each word LSB first.
- States:
  - IDLE: in_ready=1. An accepted byte is N.
    - N==0 or N>DEPTH: err<=1, stay IDLE, cpu_hold unchanged.
    - Otherwise: err<=0, cpu_hold<=1, word counter<=0, byte counter<=0, go to DATA.
  - DATA: in_ready=1. Each accepted byte shifts into the word register at byte lane = byte counter (0..3); the byte counter wraps 3->0.
    - On the 4th byte of a word (accept edge t): imem_we=1 in cycle t+1, imem_waddr=word index, imem_wdata=assembled word.
    - Word counter increments at the same edge.
    - If that was word N-1, go to DONE.
  - DONE: in_ready=0 for one cycle; this is the cycle carrying the final imem_we. At the next edge done<=1 for exactly one cycle, cpu_hold<=0, go to IDLE.
- Latency: final data byte accepted at edge t -> last imem_we in cycle t+1 -> done=1 and cpu_hold=0 in cycle t+2.
- Stalls: in_valid low mid-word is allowed indefinitely; partial-word state is held.
- Back-to-back words: a 4th byte at edge t and the next word's 1st byte at t+1 are legal. Write pulses never overlap because each word needs at least 4 accepts.
- Reload: a new header in IDLE after a completed load re-asserts cpu_hold the cycle after the header is accepted; memory is overwritten from address 0.
- Reset mid-frame: all state returns to reset values, cpu_hold=1; the partially written image is not erased.
- imem_waddr is zero-extended word index; it never exceeds DEPTH-1.

Optional Feature:
- Macro IMEM_LOADER_CHKSUM_EN.
- Defined:
  - A running XOR of all 4*N data bytes is kept, and one extra trailing checksum byte follows the last data byte.
  - Extra state CHK, with in_ready=1, entered after the last data byte.
  - Match: behave as DONE.
  - Mismatch: err<=1, done stays 0, cpu_hold stays 1, return to IDLE.
  - The last imem_we still occurs in the cycle after the last data byte.
- Undefined: no checksum byte; frame ends after the data bytes, as above.

Decomposition:
- Package imem_loader_pkg:
  - state encoding constants IDLE/DATA/CHK/DONE (2 bits).
  - IMEM_DEPTH=64, IMEM_ADDR_W=8, BYTES_PER_WORD=4.
- One sub-module, imem_word_packer:
  - Byte lane counter plus 32-bit shift register.
  - Outputs word_valid pulse and word.
  - Reset by rst or by a clear input asserted on header accept.

Test Plan:
- Header 0x02, bytes 13 01 00 02 93 00 10 00 with continuous valid -> imem_we at addr 0 data 0x02000113, next write addr 1 data 0x00100093; done one cycle after the last write; cpu_hold=0 from that cycle.
- Same frame with in_valid toggled 1/0 every cycle and a 5-cycle gap mid-word -> identical writes and data; no extra imem_we.
- Header 0x00, then header 0x41 (65) -> err=1 after each, no imem_we, cpu_hold=1; then valid header 0x01 + 4 bytes -> err cleared on header accept, one write, done.
- Full frame N=64 -> 64 writes, addresses 0..63 in order; last write addr 63; done pulse.
- Assert rst after 6 data bytes of an N=3 frame -> all outputs at reset values immediately (async); a fresh N=1 frame then loads to addr 0.
- IMEM_LOADER_CHKSUM_EN: N=1, bytes 13 01 00 02, checksum 0x10 -> done; repeat with checksum 0x11 -> err=1, done=0, cpu_hold=1.
